// File: rtl/mantissa_useq.sv
// Micro-sequencer for the mantissa datapath: steps a one-hot fpu_state through
// load/align/add/normalize/round. Optional build macro: MANTISSA_USEQ_NORM_SKIP_EN.
module mantissa_useq #(
   parameter int CNT_W     = 6,
   parameter int ALIGN_MAX = 32,
   parameter int NORM_MAX  = 31
) (
   input  logic             clk,
   input  logic             reset_l,
   input  logic             fpuhold,
   input  logic             op_valid,
   input  logic [2:0]       op_type,
   input  logic [CNT_W-1:0] align_cnt,
   input  logic             ae_small,
   input  logic             amsb,
   input  logic             manzero,
   output logic             op_ready,
   output logic [7:0]       fpu_state,
   output logic             cyc0_rdy,
   output logic             cyc1_rdy,
   output logic [2:0]       cyc0_type,
   output logic [2:0]       a0func,
   output logic [2:0]       a1func,
   output logic [2:0]       a2func,
   output logic [1:0]       mconfunc,
   output logic             done
);

   typedef enum logic [7:0] {
      ST_IDLE  = 8'h01,
      ST_CYC0  = 8'h02,
      ST_CYC1  = 8'h04,
      ST_ALIGN = 8'h08,
      ST_ADD   = 8'h10,
      ST_NORM  = 8'h20,
      ST_ROUND = 8'h40,
      ST_DONE  = 8'h80
   } state_t;

   localparam logic [2:0] FN_HOLD  = 3'b000;
   localparam logic [2:0] FN_LOAD  = 3'b001;
   localparam logic [2:0] FN_SHR   = 3'b010;
   localparam logic [2:0] FN_SHL   = 3'b011;
   localparam logic [2:0] FN_ADD   = 3'b100;
   localparam logic [2:0] FN_RND   = 3'b101;
   localparam logic [1:0] MC_IDLE  = 2'b00;
   localparam logic [1:0] MC_ALIGN = 2'b01;
   localparam logic [1:0] MC_ADD   = 2'b10;
   localparam logic [1:0] MC_RND   = 2'b11;
   localparam logic [2:0] OP_CMP   = 3'b010;
   localparam logic [2:0] OP_MOV   = 3'b011;

   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] ALIGN_MAX_C = CNT_W'(ALIGN_MAX);
   localparam logic [CNT_W-1:0] NORM_MAX_C  = CNT_W'(NORM_MAX);

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [2:0]       type_r, type_s;
   logic [2:0]       a0_r, a1_r, a2_r, a0_s, a1_s, a2_s;
   logic [1:0]       mc_r, mc_s;
   logic             is_mov_s, is_cmp_s;

   // Reserved op codes (1xx) behave as mov.
   assign is_mov_s = type_r[2] | (type_r == OP_MOV);
   assign is_cmp_s = (type_r == OP_CMP);

   // Next-state, counter, latched op and next function codes.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      type_s  = type_r;
      a0_s    = FN_HOLD;
      a1_s    = FN_HOLD;
      a2_s    = FN_HOLD;
      mc_s    = MC_IDLE;
      if (fpuhold) begin
         state_s = state_r;
         cnt_s   = cnt_r;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (op_valid) begin
                  type_s  = op_type;
                  state_s = ST_CYC0;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_CYC0: begin
               a0_s    = FN_LOAD;
               state_s = ST_CYC1;
            end
            ST_CYC1: begin
               a1_s  = FN_LOAD;
               cnt_s = (align_cnt > ALIGN_MAX_C) ? ALIGN_MAX_C : align_cnt;
               if (is_mov_s) begin
                  state_s = ST_DONE;
               end else if (align_cnt == CNT_ZERO) begin
                  state_s = ST_ADD;
               end else begin
                  state_s = ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               mc_s = MC_ALIGN;
               if (ae_small) begin
                  a0_s = FN_SHR;
               end else begin
                  a1_s = FN_SHR;
               end
               cnt_s = cnt_r - CNT_ONE;
               // Leaving on count 1 gives exactly N align cycles for a load of N.
               if (cnt_r <= CNT_ONE) begin
                  state_s = ST_ADD;
               end else begin
                  state_s = ST_ALIGN;
               end
            end
            ST_ADD: begin
               a2_s = FN_ADD;
               mc_s = MC_ADD;
               if (is_cmp_s) begin
                  state_s = ST_DONE;
               end else begin
                  cnt_s = CNT_ZERO;
`ifdef MANTISSA_USEQ_NORM_SKIP_EN
                  if (amsb) begin
                     state_s = ST_ROUND;
                  end else begin
                     state_s = ST_NORM;
                  end
`else
                  state_s = ST_NORM;
`endif
               end
            end
            ST_NORM: begin
               if (manzero || amsb) begin
                  state_s = ST_ROUND;
               end else begin
                  a1_s  = FN_SHL;
                  cnt_s = cnt_r + CNT_ONE;
                  if ((cnt_r + CNT_ONE) == NORM_MAX_C) begin
                     state_s = ST_ROUND;
                  end else begin
                     state_s = ST_NORM;
                  end
               end
            end
            ST_ROUND: begin
               a2_s    = FN_RND;
               mc_s    = MC_RND;
               state_s = ST_DONE;
            end
            ST_DONE: begin
               state_s = ST_IDLE;
            end
            default: begin
               state_s = ST_IDLE;
               cnt_s   = CNT_ZERO;
            end
         endcase
      end
   end

   // State, counter, latched op and registered function codes.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         type_r  <= 3'b000;
         a0_r    <= FN_HOLD;
         a1_r    <= FN_HOLD;
         a2_r    <= FN_HOLD;
         mc_r    <= MC_IDLE;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         type_r  <= type_s;
         a0_r    <= a0_s;
         a1_r    <= a1_s;
         a2_r    <= a2_s;
         mc_r    <= mc_s;
      end
   end

   assign fpu_state = state_r;
   assign op_ready  = state_r[0];
   assign cyc0_rdy  = state_r[1];
   assign cyc1_rdy  = state_r[2];
   assign done      = state_r[7];
   assign cyc0_type = type_r;
   assign a0func    = a0_r;
   assign a1func    = a1_r;
   assign a2func    = a2_r;
   assign mconfunc  = mc_r;

endmodule

// File: tb/tb_mantissa_useq.sv
// Randomized bench for mantissa_useq against a per-op phase-list model.
// Function codes are expected one cycle after the phase that requests them.
module tb_mantissa_useq;

   logic       clk = 1'b0;
   logic       reset_l, fpuhold, op_valid, ae_small, amsb, manzero;
   logic [2:0] op_type;
   logic [5:0] align_cnt;
   logic       op_ready, cyc0_rdy, cyc1_rdy, done;
   logic [7:0] fpu_state;
   logic [2:0] cyc0_type, a0func, a1func, a2func;
   logic [1:0] mconfunc;

   mantissa_useq dut (
      .clk(clk), .reset_l(reset_l), .fpuhold(fpuhold), .op_valid(op_valid),
      .op_type(op_type), .align_cnt(align_cnt), .ae_small(ae_small), .amsb(amsb),
      .manzero(manzero), .op_ready(op_ready), .fpu_state(fpu_state),
      .cyc0_rdy(cyc0_rdy), .cyc1_rdy(cyc1_rdy), .cyc0_type(cyc0_type),
      .a0func(a0func), .a1func(a1func), .a2func(a2func), .mconfunc(mconfunc),
      .done(done)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] st; logic hold; logic amsb; logic mz; logic [10:0] fn; } cyc_t;
   typedef struct { logic [7:0] st; logic [3:0] strb; logic [2:0] typ; logic [10:0] fn; } obs_t;

   cyc_t       plan[$];
   obs_t       obs[$];
   logic [2:0] plan_op;
   int         plan_acnt;
   logic       plan_aes;
   logic [10:0] last_fn;
   logic [2:0]  last_typ;
   int n_vec = 0;
   int n_err = 0;

   function automatic logic [10:0] fnp(input logic [2:0] a0, a1, a2, input logic [1:0] mc);
      return {a0, a1, a2, mc};
   endfunction

   task automatic add_cyc(input logic [7:0] st, input logic hold, input logic am,
                          input logic mz, input logic [10:0] fn);
      cyc_t c;
      c.st = st; c.hold = hold; c.amsb = am; c.mz = mz; c.fn = fn;
      plan.push_back(c);
   endtask

   // Expected phase list of one op, written from the sequencing rules.
   task automatic build_plan(input logic [2:0] op, input int acnt, input logic aes,
                             input logic add_amsb, input int norm_k, input logic norm_zero,
                             input int hold_at, input int hold_len);
      int  n;
      bit  is_mov, is_cmp, skip;
      plan.delete();
      plan_op = op; plan_acnt = acnt; plan_aes = aes;
      is_mov = (op >= 3'd3);
      is_cmp = (op == 3'd2);
      add_cyc(8'h01, 1'b0, 1'b0, 1'b0, 11'd0);
      add_cyc(8'h02, 1'b0, 1'b0, 1'b0, fnp(3'd1, 3'd0, 3'd0, 2'd0));
      add_cyc(8'h04, 1'b0, 1'b0, 1'b0, fnp(3'd0, 3'd1, 3'd0, 2'd0));
      if (!is_mov) begin
         n = (acnt > 32) ? 32 : acnt;
         for (int i = 0; i < n; i++) begin
            if (i == hold_at)
               for (int h = 0; h < hold_len; h++) add_cyc(8'h08, 1'b1, 1'b0, 1'b0, 11'd0);
            add_cyc(8'h08, 1'b0, 1'b0, 1'b0,
                    fnp(aes ? 3'd2 : 3'd0, aes ? 3'd0 : 3'd2, 3'd0, 2'd1));
         end
         add_cyc(8'h10, 1'b0, add_amsb, 1'b0, fnp(3'd0, 3'd0, 3'd4, 2'd2));
         if (!is_cmp) begin
            skip = 1'b0;
`ifdef MANTISSA_USEQ_NORM_SKIP_EN
            skip = add_amsb;
`endif
            if (!skip) begin
               for (int j = 0; j < 31; j++) begin
                  if (j == norm_k) begin
                     add_cyc(8'h20, 1'b0, norm_zero ? 1'($urandom_range(0, 1)) : 1'b1,
                             norm_zero, 11'd0);
                     break;
                  end
                  add_cyc(8'h20, 1'b0, 1'b0, 1'b0, fnp(3'd0, 3'd3, 3'd0, 2'd0));
               end
            end
            add_cyc(8'h40, 1'b0, 1'b0, 1'b0, fnp(3'd0, 3'd0, 3'd5, 2'd3));
         end
      end
      add_cyc(8'h80, 1'b0, 1'b0, 1'b0, 11'd0);
   endtask

   // Drives ncyc cycles of the plan and records outputs at each falling edge.
   task automatic run_plan(input int ncyc);
      obs_t o;
      obs.delete();
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk); #1;
         fpuhold   = plan[i].hold;
         op_valid  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         op_type   = (i == 0) ? plan_op : 3'($urandom_range(0, 7));
         align_cnt = (plan[i].st == 8'h04) ? 6'(plan_acnt) : 6'($urandom_range(0, 63));
         ae_small  = plan_aes;
         amsb      = plan[i].amsb;
         manzero   = plan[i].mz;
         @(negedge clk);
         o.st = fpu_state; o.strb = {op_ready, cyc0_rdy, cyc1_rdy, done};
         o.typ = cyc0_type; o.fn = {a0func, a1func, a2func, mconfunc};
         obs.push_back(o);
      end
   endtask

   task automatic test_reset;
      reset_l = 1'b0; fpuhold = 1'b0; op_valid = 1'b0; op_type = 3'd0; align_cnt = 6'd0;
      ae_small = 1'b0; amsb = 1'b0; manzero = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if (fpu_state !== 8'h01) begin
         n_err++; $display("FAIL reset_state got %h expected 01", fpu_state);
      end
      n_vec++;
      if ({a0func, a1func, a2func, mconfunc} !== 11'd0) begin
         n_err++; $display("FAIL reset_func got %h expected 000", {a0func, a1func, a2func, mconfunc});
      end
      n_vec++;
      if ({cyc0_type, done, op_ready, cyc0_rdy, cyc1_rdy} !== 7'b000_0100) begin
         n_err++; $display("FAIL reset_misc got %b expected 0000100", {cyc0_type, done, op_ready, cyc0_rdy, cyc1_rdy});
      end
      #2 reset_l = 1'b1;
      last_fn = 11'd0; last_typ = 3'd0;
   endtask

   task automatic test_add_align;
      int sh, dn;
      build_plan(3'd0, 3, 1'b1, 1'b1, 0, 1'b0, -1, 0);
      run_plan(plan.size());
      sh = 0; dn = 0;
      for (int i = 0; i < obs.size(); i++) begin
         n_vec++;
         if (obs[i].st !== plan[i].st || obs[i].strb !== {plan[i].st[0], plan[i].st[1], plan[i].st[2], plan[i].st[7]} ||
             obs[i].typ !== ((i == 0) ? last_typ : plan_op) || obs[i].fn !== ((i == 0) ? last_fn : plan[i-1].fn)) begin
            n_err++;
            $display("FAIL add_trace cyc %0d got st=%h strb=%b typ=%0d fn=%h expected st=%h fn=%h", i,
                     obs[i].st, obs[i].strb, obs[i].typ, obs[i].fn, plan[i].st, (i == 0) ? last_fn : plan[i-1].fn);
         end
         if (obs[i].fn[10:8] == 3'b010) sh++;
         if (obs[i].strb[0]) dn++;
      end
      last_fn = plan[plan.size()-1].fn; last_typ = plan_op;
      n_vec++;
      if (sh != 3 || dn != 1) begin
         n_err++; $display("FAIL add_counts got shifts=%0d done=%0d expected 3 and 1", sh, dn);
      end
   endtask

   task automatic test_norm_loop;
      int sh;
      build_plan(3'd1, 0, 1'b0, 1'b0, 4, 1'b0, -1, 0);
      run_plan(plan.size());
      sh = 0;
      for (int i = 0; i < obs.size(); i++) begin
         n_vec++;
         if (obs[i].st !== plan[i].st || obs[i].strb !== {plan[i].st[0], plan[i].st[1], plan[i].st[2], plan[i].st[7]} ||
             obs[i].typ !== ((i == 0) ? last_typ : plan_op) || obs[i].fn !== ((i == 0) ? last_fn : plan[i-1].fn)) begin
            n_err++;
            $display("FAIL norm_trace cyc %0d got st=%h typ=%0d fn=%h expected st=%h fn=%h", i,
                     obs[i].st, obs[i].typ, obs[i].fn, plan[i].st, (i == 0) ? last_fn : plan[i-1].fn);
         end
         if (obs[i].fn[7:5] == 3'b011) sh++;
      end
      last_fn = plan[plan.size()-1].fn; last_typ = plan_op;
      n_vec++;
      if (sh != 4) begin
         n_err++; $display("FAIL norm_shifts got %0d expected 4", sh);
      end
   endtask

   task automatic test_boundaries;
      int m;
      int exp_m [3] = '{0, 32, 31};
      for (int s = 0; s < 3; s++) begin
         case (s)
            0:       build_plan(3'd0, 2, 1'b0, 1'b0, 0, 1'b1, -1, 0);
            1:       build_plan(3'd1, 40, 1'b0, 1'b0, 0, 1'b0, -1, 0);
            default: build_plan(3'd0, 0, 1'b1, 1'b0, 99, 1'b0, -1, 0);
         endcase
         run_plan(plan.size());
         m = 0;
         for (int i = 0; i < obs.size(); i++) begin
            n_vec++;
            if (obs[i].st !== plan[i].st || obs[i].strb !== {plan[i].st[0], plan[i].st[1], plan[i].st[2], plan[i].st[7]} ||
                obs[i].typ !== ((i == 0) ? last_typ : plan_op) || obs[i].fn !== ((i == 0) ? last_fn : plan[i-1].fn)) begin
               n_err++;
               $display("FAIL bound%0d_trace cyc %0d got st=%h fn=%h expected st=%h fn=%h", s, i,
                        obs[i].st, obs[i].fn, plan[i].st, (i == 0) ? last_fn : plan[i-1].fn);
            end
            if (s == 1 && obs[i].st == 8'h08) m++;
            if (s != 1 && obs[i].fn[7:5] == 3'b011) m++;
         end
         last_fn = plan[plan.size()-1].fn; last_typ = plan_op;
         n_vec++;
         if (m != exp_m[s]) begin
            n_err++; $display("FAIL bound%0d_count got %0d expected %0d", s, m, exp_m[s]);
         end
      end
   endtask

   task automatic test_cmp_mov;
      int extra, adds;
      logic [2:0] ops [3] = '{3'd2, 3'd3, 3'd6};
      for (int s = 0; s < 3; s++) begin
         build_plan(ops[s], (s == 0) ? 0 : 5, 1'b0, 1'b1, 0, 1'b0, -1, 0);
         run_plan(plan.size());
         extra = 0; adds = 0;
         for (int i = 0; i < obs.size(); i++) begin
            n_vec++;
            if (obs[i].st !== plan[i].st || obs[i].strb !== {plan[i].st[0], plan[i].st[1], plan[i].st[2], plan[i].st[7]} ||
                obs[i].typ !== ((i == 0) ? last_typ : plan_op) || obs[i].fn !== ((i == 0) ? last_fn : plan[i-1].fn)) begin
               n_err++;
               $display("FAIL cmpmov%0d_trace cyc %0d got st=%h typ=%0d fn=%h expected st=%h typ=%0d", s, i,
                        obs[i].st, obs[i].typ, obs[i].fn, plan[i].st, (i == 0) ? last_typ : plan_op);
            end
            if (obs[i].st == 8'h08 || obs[i].st == 8'h20 || obs[i].st == 8'h40) extra++;
            if (obs[i].st == 8'h10) adds++;
         end
         last_fn = plan[plan.size()-1].fn; last_typ = plan_op;
         n_vec++;
         if (extra != 0 || adds != ((s == 0) ? 1 : 0)) begin
            n_err++; $display("FAIL cmpmov%0d_path got extra=%0d add=%0d expected 0 and %0d", s, extra, adds, (s == 0) ? 1 : 0);
         end
      end
   endtask

   task automatic test_hold;
      int sh, al;
      build_plan(3'd0, 6, 1'b0, 1'b1, 0, 1'b0, 2, 3);
      run_plan(plan.size());
      sh = 0; al = 0;
      for (int i = 0; i < obs.size(); i++) begin
         n_vec++;
         if (obs[i].st !== plan[i].st || obs[i].strb !== {plan[i].st[0], plan[i].st[1], plan[i].st[2], plan[i].st[7]} ||
             obs[i].typ !== ((i == 0) ? last_typ : plan_op) || obs[i].fn !== ((i == 0) ? last_fn : plan[i-1].fn)) begin
            n_err++;
            $display("FAIL hold_trace cyc %0d got st=%h fn=%h expected st=%h fn=%h", i,
                     obs[i].st, obs[i].fn, plan[i].st, (i == 0) ? last_fn : plan[i-1].fn);
         end
         if (obs[i].fn[7:5] == 3'b010) sh++;
         if (obs[i].st == 8'h08) al++;
      end
      last_fn = plan[plan.size()-1].fn; last_typ = plan_op;
      n_vec++;
      if (sh != 6 || al != 9) begin
         n_err++; $display("FAIL hold_counts got shifts=%0d align_states=%0d expected 6 and 9", sh, al);
      end
   endtask

   task automatic test_random;
      for (int k = 0; k < 25; k++) begin
         build_plan(3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(33, 63)) : int'($urandom_range(0, 8)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 34)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1,
                    int'($urandom_range(1, 3)));
         run_plan(plan.size());
         for (int i = 0; i < obs.size(); i++) begin
            n_vec++;
            if (obs[i].st !== plan[i].st || obs[i].strb !== {plan[i].st[0], plan[i].st[1], plan[i].st[2], plan[i].st[7]} ||
                obs[i].typ !== ((i == 0) ? last_typ : plan_op) || obs[i].fn !== ((i == 0) ? last_fn : plan[i-1].fn)) begin
               n_err++;
               $display("FAIL rand%0d_trace cyc %0d op=%0d got st=%h typ=%0d fn=%h expected st=%h fn=%h", k, i, plan_op,
                        obs[i].st, obs[i].typ, obs[i].fn, plan[i].st, (i == 0) ? last_fn : plan[i-1].fn);
            end
         end
         last_fn = plan[plan.size()-1].fn; last_typ = plan_op;
      end
   endtask

   task automatic test_reset_mid_op;
      build_plan(3'd0, 10, 1'b1, 1'b0, 2, 1'b0, -1, 0);
      run_plan(9);
      for (int i = 0; i < obs.size(); i++) begin
         n_vec++;
         if (obs[i].st !== plan[i].st || obs[i].fn !== ((i == 0) ? last_fn : plan[i-1].fn)) begin
            n_err++;
            $display("FAIL rstmid_trace cyc %0d got st=%h fn=%h expected st=%h fn=%h", i,
                     obs[i].st, obs[i].fn, plan[i].st, (i == 0) ? last_fn : plan[i-1].fn);
         end
      end
      #1 reset_l = 1'b0;
      op_valid = 1'b0;
      #1;
      n_vec++;
      if (fpu_state !== 8'h01 || {a0func, a1func, a2func, mconfunc} !== 11'd0 || done !== 1'b0) begin
         n_err++; $display("FAIL rstmid_immediate got st=%h fn=%h done=%b expected 01 000 0",
                           fpu_state, {a0func, a1func, a2func, mconfunc}, done);
      end
      #1 reset_l = 1'b1;
      @(negedge clk);
      n_vec++;
      if (fpu_state !== 8'h01 || op_ready !== 1'b1 || cyc0_type !== 3'd0 || {a0func, a1func, a2func, mconfunc} !== 11'd0) begin
         n_err++; $display("FAIL rstmid_release got st=%h ready=%b type=%0d fn=%h expected 01 1 0 000",
                           fpu_state, op_ready, cyc0_type, {a0func, a1func, a2func, mconfunc});
      end
   endtask

   initial begin
      test_reset;
      test_add_align;
      test_norm_loop;
      test_boundaries;
      test_cmp_mov;
      test_hold;
      test_random;
      test_reset_mid_op;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mantissa_useq.md
Name: mantissa_useq

Overview:
- Micro-sequencer that drives the mantissa datapath control block.
- Accepts one FP op at a time from the FPU decode stage.
- Steps a one-hot fpu_state through load, align, add, normalize and round phases.
- Emits the a0func/a1func/a2func/mconfunc codes, plus the cyc0/cyc1 handshakes, that the mantissa control block decodes into mux selects.
- Consumes the datapath status flags (amsb, manzero) to close the normalize loop.

Parameters:
- CNT_W, 6, width of the shared align/normalize counter.
- ALIGN_MAX, 32, saturation limit for the alignment shift count.
- NORM_MAX, 31, maximum left-normalize shifts before forcing ROUND.

Ports:
- clk  in  1  clock; all flops rising-edge.
- reset_l  in  1  asynchronous active-low reset.
- fpuhold  in  1  pipeline hold; freezes all state.
- op_valid  in  1  op request from decode.
- op_type  in  3  000 add, 001 sub, 010 cmp, 011 mov; others reserved, treated as mov.
- align_cnt  in  CNT_W  exponent difference from the exponent datapath; sampled in CYC1.
- ae_small  in  1  A exponent smaller; selects which operand aligns.
- amsb  in  1  A mantissa MSB after the current cycle.
- manzero  in  1  mantissa result is zero.
- op_ready  out  1  high only in IDLE.
- fpu_state  out  8  one-hot state.
- cyc0_rdy  out  1  first operand cycle strobe.
- cyc1_rdy  out  1  second operand cycle strobe.
- cyc0_type  out  3  latched op_type.
- a0func, a1func, a2func  out  3 each  datapath function codes.
- mconfunc  out  2  mantissa control: 00 idle, 01 align, 10 add, 11 round.
- done  out  1  op complete.

Behaviour:
- fpu_state bit assignment: [0] IDLE, [1] CYC0, [2] CYC1, [3] ALIGN, [4] ADD, [5] NORM, [6] ROUND, [7] DONE.
- Reset values: fpu_state=8'h01, counter=0, cyc0_type=0, done=0, all func codes 000, mconfunc 00. Reset takes effect immediately, including mid-op, and any in-flight op is abandoned.
- Function code encoding: 000 hold, 001 load, 010 shift right 1, 011 shift left 1, 100 add/sub, 101 round.
- IDLE:
  - op_ready=1.
  - op_valid and not fpuhold: latch op_type into cyc0_type, go to CYC0.
- CYC0: cyc0_rdy=1, a0func=001; go to CYC1.
- CYC1:
  - cyc1_rdy=1, a1func=001.
  - Load counter = min(align_cnt, ALIGN_MAX).
  - mov: go to DONE.
  - add/sub/cmp with align_cnt=0: go to ADD.
  - otherwise: go to ALIGN.
- ALIGN:
  - mconfunc=01.
  - Shift the smaller operand right: if ae_small, a0func=010; else a1func=010.
  - Counter decrements each cycle. Leave for ADD in the cycle the counter equals 1, so exactly N ALIGN cycles for count N.
- ADD:
  - a2func=100, mconfunc=10. One cycle.
  - cmp: go to DONE. Otherwise clear the counter and go to NORM.
- NORM (exits evaluated in priority order):
  - manzero=1: go to ROUND, no shift.
  - amsb=1: go to ROUND, no shift.
  - Otherwise a1func=011 and the counter increments; when the counter reaches NORM_MAX, go to ROUND after that shift.
- ROUND: a2func=101, mconfunc=11; go to DONE.
- DONE: done=1 for one cycle; go to IDLE. op_ready rises the next cycle; there is no back-to-back accept from DONE.
- Output timing: all outputs are registered or decoded from the state/counter registers only; no combinational path from inputs to outputs.
- fpuhold=1:
  - State, counter and cyc0_type hold.
  - All func codes and mconfunc are forced to 000/00.
  - cyc0_rdy, cyc1_rdy and done stay at their state-decoded values.
  - op_valid is ignored.
- op_valid while not in IDLE is ignored. Requesters must wait for op_ready.

Optional Feature:
- MANTISSA_USEQ_NORM_SKIP_EN defined: in ADD, if amsb=1 and op is not cmp, go directly to ROUND, skipping NORM.
- Undefined: NORM is always visited for at least one cycle after ADD on add/sub.

Test Plan:
- Reset mid-op: reset_l low during ALIGN with counter=5 -> fpu_state=8'h01 and func codes 000 immediately; op_ready=1 after release.
- Add with align_cnt=3, ae_small=1, amsb=1 at ADD -> macro off: states 01,02,04,08×3,10,20,40,80; 3 cycles of a0func=010; done one cycle.
- Normalize loop: sub, align_cnt=0, amsb low for 4 NORM cycles then high -> exactly 4 cycles of a1func=011, then ROUND.
- Boundaries: manzero=1 in NORM -> ROUND with no shift; align_cnt=40 -> exactly 32 ALIGN cycles; amsb never set -> 31 shifts then ROUND.
- cmp and mov: cmp takes CYC0, CYC1, ADD, DONE; mov takes CYC0, CYC1, DONE; cyc0_type equals 010 or 011 throughout.
- fpuhold asserted 3 cycles during ALIGN -> state and counter frozen, func codes 000; total ALIGN-active cycles unchanged.
